// File: rtl/cpu_axi_bridge_pkg.sv
// Shared constants for the CPU-to-AXI bridge: ids, size encodings,
// payload field widths and offsets.
package cpu_axi_bridge_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 3;

    localparam int unsigned AR_W = ID_W + ADDR_W + SIZE_W;
    localparam int unsigned AW_W = ADDR_W + SIZE_W;
    localparam int unsigned W_W  = DATA_W + STRB_W;
    localparam int unsigned R_W  = ID_W + DATA_W;

    localparam int unsigned R_ID_LSB = DATA_W;

    localparam logic [ID_W-1:0] AXI_ID_INST = 4'd0;
    localparam logic [ID_W-1:0] AXI_ID_DATA = 4'd1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [SIZE_W-1:0] axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_chan_reg.sv
// One-entry valid/ready holding register: loads a payload, holds valid and a
// stable payload until the downstream handshake.
module axi_chan_reg
    import cpu_axi_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] payload_o
);

    logic             valid_q;
    logic [WIDTH-1:0] payload_q;

    // load_i is only raised while the owning FSM is idle, so it never
    // collides with a pending handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Arbitrates the instruction-fetch and data SRAM-like ports onto a single AXI
// master, one outstanding transaction per requester.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = AXI_ID_INST,
    parameter logic [3:0] DATA_ID = AXI_ID_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [38:0] ar_payload,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [35:0] r_payload,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [34:0] aw_payload,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [35:0] w_payload,
    input  logic        b_valid,
    output logic        b_ready
);

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_BUSY = 1'b1;
    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_BUSY  = 1'b1;

    logic [0:0] ar_state_q, ar_state_d;
    logic [0:0] w_state_q, w_state_d;
    logic       inst_busy_q, inst_busy_d;
    logic       data_busy_q, data_busy_d;

    logic            data_rd_acc, inst_rd_acc, data_wr_acc;
    logic [ID_W-1:0] rid;
    logic            r_inst, r_data;
    logic [AR_W-1:0] ar_data;

    assign rid    = r_payload[R_ID_LSB +: ID_W];
    assign r_inst = r_valid && (rid == INST_ID);
    assign r_data = r_valid && (rid == DATA_ID);

    // Data beats inst for the read channel; stores only need the W path idle.
    assign data_rd_acc = !reset && (ar_state_q == AR_IDLE) && data_req && !data_wr && !data_busy_q;
    assign inst_rd_acc = !reset && (ar_state_q == AR_IDLE) && inst_req && !inst_busy_q && !data_rd_acc;
    assign data_wr_acc = !reset && (w_state_q == W_IDLE) && data_req && data_wr && !data_busy_q;

    assign ar_data = data_rd_acc ? {DATA_ID, data_addr, axsize(data_size)}
                                 : {INST_ID, inst_addr, axsize(SIZE_WORD)};

    always_comb begin
        ar_state_d  = ar_state_q;
        w_state_d   = w_state_q;
        inst_busy_d = inst_busy_q;
        data_busy_d = data_busy_q;

        if (ar_state_q == AR_IDLE) begin
            if (data_rd_acc || inst_rd_acc) ar_state_d = AR_BUSY;
        end else if (ar_valid && ar_ready) begin
            ar_state_d = AR_IDLE;
        end

        if (w_state_q == W_IDLE) begin
            if (data_wr_acc) w_state_d = W_BUSY;
        end else if ((!aw_valid || aw_ready) && (!w_valid || w_ready)) begin
            w_state_d = W_IDLE;
        end

        if (r_inst)      inst_busy_d = 1'b0;
        if (inst_rd_acc) inst_busy_d = 1'b1;

        if (r_data || b_valid)          data_busy_d = 1'b0;
        if (data_rd_acc || data_wr_acc) data_busy_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q  <= AR_IDLE;
            w_state_q   <= W_IDLE;
            inst_busy_q <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            ar_state_q  <= ar_state_d;
            w_state_q   <= w_state_d;
            inst_busy_q <= inst_busy_d;
            data_busy_q <= data_busy_d;
        end
    end

    axi_chan_reg #(.WIDTH(AR_W)) u_ar (
        .clk       (clk),
        .reset     (reset),
        .load_i    (data_rd_acc || inst_rd_acc),
        .data_i    (ar_data),
        .ready_i   (ar_ready),
        .valid_o   (ar_valid),
        .payload_o (ar_payload)
    );

    axi_chan_reg #(.WIDTH(AW_W)) u_aw (
        .clk       (clk),
        .reset     (reset),
        .load_i    (data_wr_acc),
        .data_i    ({data_addr, axsize(data_size)}),
        .ready_i   (aw_ready),
        .valid_o   (aw_valid),
        .payload_o (aw_payload)
    );

    axi_chan_reg #(.WIDTH(W_W)) u_w (
        .clk       (clk),
        .reset     (reset),
        .load_i    (data_wr_acc),
        .data_i    ({data_wdata, data_wstrb}),
        .ready_i   (w_ready),
        .valid_o   (w_valid),
        .payload_o (w_payload)
    );

    assign inst_addr_ok = inst_rd_acc;
    assign data_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_data_ok = r_inst;
    assign data_data_ok = r_data || b_valid;
    assign inst_rdata   = r_payload[DATA_W-1:0];
    assign data_rdata   = r_payload[DATA_W-1:0];
    assign r_ready      = 1'b1;
    assign b_ready      = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: fetch, arbitration, out-of-order R,
// store with delayed AW, blocked load, AR back-pressure and reset.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        ar_valid, ar_ready;
    logic [38:0] ar_payload;
    logic        r_valid, r_ready;
    logic [35:0] r_payload;
    logic        aw_valid, aw_ready;
    logic [34:0] aw_payload;
    logic        w_valid, w_ready;
    logic [35:0] w_payload;
    logic        b_valid, b_ready;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload(ar_payload),
        .r_valid(r_valid), .r_ready(r_ready), .r_payload(r_payload),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload),
        .w_valid(w_valid), .w_ready(w_ready), .w_payload(w_payload),
        .b_valid(b_valid), .b_ready(b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run 1ns later still.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [38:0] ar_exp;

        reset = 1'b1; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
        data_wstrb = '0; data_wdata = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_payload = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        settle();
        check("rst_ar_valid", ar_valid, 0);
        check("rst_aw_valid", aw_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_ar_payload", ar_payload, 0);
        check("rst_r_ready", r_ready, 1);
        check("rst_b_ready", b_ready, 1);

        // Single fetch
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; ar_ready = 1'b1;
        settle();
        check("f_inst_addr_ok", inst_addr_ok, 1);
        check("f_data_addr_ok", data_addr_ok, 0);
        step();
        inst_req = 1'b0;
        settle();
        check("f_ar_valid", ar_valid, 1);
        check("f_ar_payload", ar_payload, {4'd0, 32'h1C00_0000, 3'd2});
        step(); settle();
        check("f_ar_drop", ar_valid, 0);
        step(); step();
        r_valid = 1'b1; r_payload = {4'd0, 32'h0280_0C0C};
        settle();
        check("f_inst_data_ok", inst_data_ok, 1);
        check("f_inst_rdata", inst_rdata, 32'h0280_0C0C);
        check("f_data_data_ok", data_data_ok, 0);
        step();
        r_valid = 1'b0;
        settle();
        check("f_inst_data_ok_off", inst_data_ok, 0);

        // Simultaneous inst and data load: data wins
        ar_ready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80;
        settle();
        check("a_data_addr_ok", data_addr_ok, 1);
        check("a_inst_addr_ok", inst_addr_ok, 0);
        step();
        data_req = 1'b0;
        settle();
        check("a_ar_valid", ar_valid, 1);
        check("a_ar_payload_d", ar_payload, {4'd1, 32'h80, 3'd2});
        check("a_inst_blocked", inst_addr_ok, 0);
        ar_ready = 1'b1;
        step(); settle();
        check("a_inst_addr_ok2", inst_addr_ok, 1);
        step();
        inst_req = 1'b0;
        settle();
        check("a_ar_payload_i", ar_payload, {4'd0, 32'h1C00_0004, 3'd2});
        step();
        r_valid = 1'b1; r_payload = {4'd0, 32'h1111_1111};
        settle();
        check("a_r0_inst_ok", inst_data_ok, 1);
        check("a_r0_data_ok", data_data_ok, 0);
        check("a_r0_rdata", inst_rdata, 32'h1111_1111);
        step();
        r_payload = {4'd1, 32'h2222_2222};
        settle();
        check("a_r1_data_ok", data_data_ok, 1);
        check("a_r1_inst_ok", inst_data_ok, 0);
        check("a_r1_rdata", data_rdata, 32'h2222_2222);
        step();
        r_payload = {4'd5, 32'h3333_3333};
        settle();
        check("u_inst_ok", inst_data_ok, 0);
        check("u_data_ok", data_data_ok, 0);
        step();
        r_valid = 1'b0;

        // Store with AW delayed, W immediate
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h100;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        settle();
        check("s_addr_ok", data_addr_ok, 1);
        step();
        data_req = 1'b0;
        settle();
        check("s_aw_valid1", aw_valid, 1);
        check("s_w_valid1", w_valid, 1);
        check("s_aw_payload", aw_payload, {32'h100, 3'd2});
        check("s_w_payload", w_payload, {32'hDEAD_BEEF, 4'hF});
        step(); settle();
        check("s_w_valid2", w_valid, 0);
        check("s_aw_valid2", aw_valid, 1);
        step();
        aw_ready = 1'b1;
        settle();
        check("s_aw_valid3", aw_valid, 1);
        step();
        // Load while the store awaits B
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
        settle();
        check("s_aw_valid4", aw_valid, 0);
        check("l_blocked1", data_addr_ok, 0);
        check("s_no_ok_yet", data_data_ok, 0);
        step(); settle();
        check("l_blocked2", data_addr_ok, 0);
        step();
        b_valid = 1'b1;
        settle();
        check("s_b_data_ok", data_data_ok, 1);
        check("l_blocked3", data_addr_ok, 0);
        step();
        b_valid = 1'b0;
        settle();
        check("l_accept", data_addr_ok, 1);
        step();
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C00_0008;
        ar_exp = {4'd1, 32'h200, 3'd2};
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_ar_valid", ar_valid, 1);
            check("bp_ar_payload", ar_payload, ar_exp);
            check("bp_no_inst_accept", inst_addr_ok, 0);
            step();
        end

        // Reset while AR busy
        reset = 1'b1;
        settle();
        check("r1_addr_ok_in_reset", inst_addr_ok, 0);
        step();
        inst_req = 1'b0;
        settle();
        check("r1_ar_valid", ar_valid, 0);
        reset = 1'b0;

        // Fill AR and W paths, then reset
        inst_req = 1'b1; inst_addr = 32'h1C00_000C;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h104; data_size = 2'd0;
        data_wstrb = 4'h1; data_wdata = 32'h0000_00AA; aw_ready = 1'b0; w_ready = 1'b0;
        settle();
        check("r2_inst_ok", inst_addr_ok, 1);
        check("r2_store_ok", data_addr_ok, 1);
        step();
        inst_req = 1'b0; data_req = 1'b0;
        settle();
        check("r2_aw_payload", aw_payload, {32'h104, 3'd0});
        check("r2_all_valid", {ar_valid, aw_valid, w_valid}, 3'b111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("r2_valids_clr", {ar_valid, aw_valid, w_valid}, 3'b000);
        check("r2_payload_clr", w_payload, 0);
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
        settle();
        check("r2_inst_reaccept", inst_addr_ok, 1);
        check("r2_data_reaccept", data_addr_ok, 1);
        step();
        inst_req = 1'b0; data_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
